rf_wb_arbiter: RTL

Write-back arbiter and sequencer for the 32x32 register file's single write port (RegWrite/Rd/Write_data).
- Shares the port between NUM_REQ write-back sources (ALU, load unit, CSR/debug) with round-robin arbitration and a valid/ready handshake.
- After reset it sweeps x1..x31 to INIT_VALUE through the same port, so the register file gets a deterministic clear without relying on its own reset.
- Sits between the execute/memory stages and reg_file.

---
 rtl/rv32_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/rf_wb_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 register-file definitions for the write-back path.
// Holds datapath widths, the x0 constant and the write-back sequencer state type.
package rv32_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]       xlen_t;

   // x0 is hardwired to zero and must never be written.
   localparam reg_addr_t REG_ZERO = 5'd0;
   // Highest architectural register; the init sweep ends here.
   localparam reg_addr_t REG_LAST = reg_addr_t'(NUM_REGS - 1);
   // The init sweep starts just above x0.
   localparam reg_addr_t REG_FIRST = 5'd1;

   // INIT: clearing x1..x31 after reset. RUN: arbitrating write-back requests.
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } wb_state_t;

   // True when a write to this register has an architectural effect.
   function automatic logic is_writable(input reg_addr_t rd);
      return rd != REG_ZERO;
   endfunction

endpackage : rv32_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant generator.
// Grants the first asserted request found at index ptr or above, wrapping
// modulo N. The caller owns and advances ptr.
module rr_arbiter #(
   parameter int N     = 3,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_any
);

   // Scan N candidates starting at ptr; the first asserted one wins.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // a value unassigned, which would otherwise infer a latch.
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int i = 0; i < N; i++) begin
         int cand;
         cand = int'(ptr) + i;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (!gnt_any && req[cand]) begin
            gnt[cand] = 1'b1;
            gnt_idx   = IDX_W'(cand);
            gnt_any   = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and sequencer for the register file's single write port.
// After reset it sweeps x1..x31 to INIT_VALUE, then shares the port between
// NUM_REQ requesters with round-robin arbitration and a valid/ready handshake.
// Writes to x0 are accepted but issued with RegWrite low.
// Optional feature macro: RF_WB_BYPASS_EN adds byp_valid/byp_rd/byp_data,
// mirroring the in-flight write so decode can forward it.
module rf_wb_arbiter
   import rv32_pkg::*;
#(
   parameter int    NUM_REQ    = 3,
   parameter xlen_t INIT_VALUE = 32'h0000_0000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
   input  logic [NUM_REQ*XLEN-1:0]       req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          init_done,
   output logic                          RegWrite,
   output logic [REG_ADDR_W-1:0]         Rd,
   output logic [XLEN-1:0]               Write_data,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id
`ifdef RF_WB_BYPASS_EN
   ,
   output logic                          byp_valid,
   output logic [REG_ADDR_W-1:0]         byp_rd,
   output logic [XLEN-1:0]               byp_data
`endif
);

   localparam int ID_W = $clog2(NUM_REQ);

   wb_state_t       state;
   reg_addr_t       sweep_idx;
   logic [ID_W-1:0] ptr;

   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_any;
   logic               xfer;
   reg_addr_t          sel_rd;
   xlen_t              sel_data;

   // Pointer value after granting requester g: the one just above it, wrapping.
   function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] g);
      if (int'(g) == NUM_REQ - 1) begin
         return '0;
      end
      return g + 1'b1;
   endfunction

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (ID_W)
   ) u_rr (
      .req     (req_valid),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // Requests are held off (never granted) until the sweep has finished.
   assign req_ready = (state == RUN) ? gnt : '0;
   assign xfer      = (state == RUN) && gnt_any;

   // Destination and data of the granted requester.
   assign sel_rd   = req_rd[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
   assign sel_data = req_data[int'(gnt_idx)*XLEN +: XLEN];

   // Sequencer: init sweep, then one registered write per accepted transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: sequential state is updated with non-blocking assignments so
         // every register samples the pre-edge values of the others.
         state      <= INIT;
         sweep_idx  <= REG_FIRST;
         ptr        <= '0;
         RegWrite   <= 1'b0;
         Rd         <= REG_ZERO;
         Write_data <= '0;
         grant_id   <= '0;
         init_done  <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               RegWrite   <= 1'b1;
               Rd         <= sweep_idx;
               Write_data <= INIT_VALUE;
               sweep_idx  <= sweep_idx + 5'd1;
               if (sweep_idx == REG_LAST) begin
                  state     <= RUN;
                  init_done <= 1'b1;
               end
            end
            RUN: begin
               if (xfer) begin
                  // An x0 request completes its handshake but never reaches
                  // the register file.
                  RegWrite   <= is_writable(sel_rd);
                  Rd         <= sel_rd;
                  Write_data <= sel_data;
                  grant_id   <= gnt_idx;
                  ptr        <= ptr_after(gnt_idx);
               end else begin
                  RegWrite <= 1'b0;
               end
            end
            default: begin
               state <= INIT;
            end
         endcase
      end
   end

`ifdef RF_WB_BYPASS_EN
   // The in-flight write is exactly the registered write-port contents.
   assign byp_valid = RegWrite;
   assign byp_rd    = Rd;
   assign byp_data  = Write_data;
`endif

endmodule : rf_wb_arbiter
